// File: rtl/spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_rx                                                           |
// | Brief   : SPI mode-0 slave receiver, MSB first, valid/ack output handshake |
// |           with sticky overrun flag. Define SPI_RX_SYNC_EN to add 2-flop    |
// |           synchronisers on sck/ss/rx when the master is asynchronous.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_rx #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   prst,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   rx,
  output logic [DATA_LENGTH-1:0] data,
  output logic                   valid,
  input  logic                   ack,
  output logic                   ovf
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_recv = 1'b1;
  localparam logic [3:0] c_last = 4'(DATA_LENGTH - 1);

  logic                   w_s_sck;
  logic                   w_s_ss;
  logic                   w_s_rx;
  logic                   w_rise;
  logic                   w_done;
  logic [DATA_LENGTH-2:0] w_sh_next;

  logic                   r_sck_d;
  logic [0:0]             r_state;
  logic [3:0]             r_cnt;
  logic [DATA_LENGTH-2:0] r_sh;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] r_sck_sync;
  logic [1:0] r_ss_sync;
  logic [1:0] r_rx_sync;

  always_ff @(posedge clk) begin
    if (prst) begin
      r_sck_sync <= 2'b00;
      r_ss_sync  <= 2'b00;
      r_rx_sync  <= 2'b00;
    end else begin
      r_sck_sync <= {r_sck_sync[0], sck};
      r_ss_sync  <= {r_ss_sync[0], ss};
      r_rx_sync  <= {r_rx_sync[0], rx};
    end
  end

  assign w_s_sck = r_sck_sync[1];
  assign w_s_ss  = r_ss_sync[1];
  assign w_s_rx  = r_rx_sync[1];
`else
  assign w_s_sck = sck;
  assign w_s_ss  = ss;
  assign w_s_rx  = rx;
`endif

  assign w_rise = w_s_sck & ~r_sck_d;
  assign w_done = (r_state == c_recv) && !w_s_ss && w_rise && (r_cnt == c_last);

  // A 2-bit word leaves a 1-bit shift register, which has no slice to keep.
  generate
    if (DATA_LENGTH > 2) begin : g_sh_wide
      assign w_sh_next = {r_sh[DATA_LENGTH-3:0], w_s_rx};
    end else begin : g_sh_narrow
      assign w_sh_next = w_s_rx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (prst) begin
      r_sck_d <= 1'b0;
      r_state <= c_idle;
      r_cnt   <= 4'd0;
      r_sh    <= '0;
      data    <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      r_sck_d <= w_s_sck;

      case (r_state)
        c_idle: begin
          r_cnt <= 4'd0;
          if (!w_s_ss) r_state <= c_recv;
        end
        c_recv: begin
          // Deselect wins over a coincident sck rise and drops the partial word.
          if (w_s_ss) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
          end else if (w_rise) begin
            if (r_cnt == c_last) begin
              data  <= {r_sh, w_s_rx};
              r_cnt <= 4'd0;
            end else begin
              r_sh  <= w_sh_next;
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= c_idle;
          r_cnt   <= 4'd0;
        end
      endcase

      if (w_done) valid <= 1'b1;
      else if (ack) valid <= 1'b0;

      if (w_done && valid && !ack) ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_rx                                                        |
// | Brief   : Self-checking bench for spi_rx (DATA_LENGTH = 8).                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_rx;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       prst = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       rx = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ovf;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  spi_rx #(.DATA_LENGTH(8)) dut (
    .clk  (clk),
    .prst (prst),
    .sck  (sck),
    .ss   (ss),
    .rx   (rx),
    .data (data),
    .valid(valid),
    .ack  (ack),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic sck_bit(input logic b);
    @(negedge clk);
    rx  = b;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  // Shifts a full word; the last bit optionally checks latency and/or
  // pulses ack in the cycle the completion is registered.
  task automatic send_word(input logic [7:0] w, input bit chk_lat, input bit ack_done);
    exp_q.push_back(w);
    for (int i = 7; i >= 1; i--) sck_bit(w[i]);
    @(negedge clk);
    rx  = w[0];
    sck = 1'b0;
    repeat (3) @(negedge clk);
    if (chk_lat) begin
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_pre_valid actual=%b required=0", valid);
      end
    end
    sck = 1'b1;
    repeat (LAT) @(negedge clk);
    if (ack_done) ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (chk_lat) begin
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL lat_valid actual=%b required=1", valid);
      end
    end
    repeat (3) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    prst = 1'b1;
    ss   = 1'b1;
    sck  = 1'b0;
    ack  = 1'b0;
    repeat (2) @(negedge clk);
    prst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data actual=%h required=00", data); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b required=0", ovf); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack actual=valid%b/ovf%b required=0/0", valid, ovf);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    ss = 1'b0;
    send_word(8'hA5, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL single_data actual=%h required=%h", data, exp); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_ack_valid actual=%b required=0", valid); end
    checks++;
    if (data !== 8'hA5) begin errors++; $display("FAIL single_ack_data actual=%h required=a5", data); end
  endtask

  task automatic test_overrun();
    do_reset();
    ss = 1'b0;
    send_word(8'h12, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_first actual=%h/%b required=%h/1", data, valid, exp);
    end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovr_first_ovf actual=%b required=0", ovf); end
    send_word(8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL ovr_data actual=%h required=%h", data, exp); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid actual=%b required=1", valid); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovr_flag actual=%b required=1", ovf); end
  endtask

  task automatic test_abort();
    do_reset();
    ss = 1'b0;
    for (int i = 0; i < 5; i++) sck_bit(1'b1);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL abort_spurious actual=%b required=0", valid); end
    ss = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL abort_data actual=%h required=%h", data, exp); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL abort_valid actual=%b required=1", valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf actual=%b required=0", ovf); end
  endtask

  task automatic test_sim_ack();
    do_reset();
    ss = 1'b0;
    send_word(8'h11, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp || valid !== 1'b1) begin
      errors++;
      $display("FAIL simack_first actual=%h/%b required=%h/1", data, valid, exp);
    end
    send_word(8'h5A, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL simack_data actual=%h required=%h", data, exp); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL simack_valid actual=%b required=1", valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL simack_ovf actual=%b required=0", ovf); end
  endtask

  // Starts from the non-zero output state left by the previous test.
  task automatic test_reset_midframe();
    ss = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) sck_bit(1'b1);
    prst = 1'b1;
    @(negedge clk);
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL mid_rst_data actual=%h required=00", data); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid actual=%b required=0", valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf actual=%b required=0", ovf); end
    @(negedge clk);
    prst = 1'b0;
    ss = 1'b1;
    repeat (6) @(negedge clk);
    ss = 1'b0;
    send_word(8'hC3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL mid_data actual=%h required=%h", data, exp); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL mid_valid actual=%b required=1", valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf actual=%b required=0", ovf); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overrun();
    test_abort();
    test_sim_ack();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx.md
# spi_rx

SPI slave receiver, mode 0 (CPOL=0, CPHA=0), MSB first. It is the receiving end paired with the slave transmitter `spi_tx`. It samples MOSI on rising `sck` edges while `ss` is low, assembles `DATA_LENGTH`-bit words, and presents each completed word on a registered output with a valid/acknowledge handshake. Everything runs in the system `clk` domain, with `sck`, `ss` and `rx` treated as asynchronous inputs.

## Interface
- `DATA_LENGTH`, default 8: word width in bits. Legal range is 2..16.
- `clk`  in  1: system clock. All logic runs on its rising edge.
- `prst`  in  1: reset. Synchronous, active-high.
- `sck`  in  1: SPI serial clock from the master.
- `ss`  in  1: slave select, active-low.
- `rx`  in  1: serial data in (MOSI).
- `data`  out  `DATA_LENGTH`: last completed word.
- `valid`  out  1: `data` holds an unacknowledged word.
- `ack`  in  1: consumer acknowledge, one `clk` pulse.
- `ovf`  out  1: sticky overrun flag.

## Operation
- **Sampled inputs.** `s_sck`, `s_ss` and `s_rx` are `sck`, `ss` and `rx` after optional synchronisation (see Configuration).
- **Edge detect.** `s_sck_d` is `s_sck` delayed by one `clk`. `rise = s_sck & ~s_sck_d`.
- **Internal state.** Shift register `sh` (`DATA_LENGTH-1` bits) and bit counter `cnt` (4 bits).
- **FSM states:** IDLE, RECV.
  - IDLE: `cnt`=0. On `s_ss`=0, go to RECV. A `rise` in the same cycle is ignored.
  - RECV, `s_ss`=1: go to IDLE and set `cnt`=0. Any partial word is discarded, and `s_ss`=1 takes priority over a simultaneous `rise`.
  - RECV, `rise` with `cnt` < `DATA_LENGTH-1`:
    - `sh <= {sh[DATA_LENGTH-3:0], s_rx}`
    - `cnt <= cnt+1`
  - RECV, `rise` with `cnt` == `DATA_LENGTH-1`:
    - `data <= {sh, s_rx}`
    - `valid <= 1`
    - `cnt <= 0`
    - Stay in RECV, so back-to-back words under one `ss` assertion are supported.
- **Handshake.**
  - `ack`=1 clears `valid` on the next edge.
  - If `ack` arrives in the same cycle as a word completion, `valid` stays 1, `data` takes the new word and `ovf` is unchanged.
  - `ack` while `valid`=0 has no effect.
- **Overrun.** A word completion while `valid`=1 and `ack`=0 sets `ovf`=1, and `data` is overwritten by the new word. `ovf` stays set until `prst`.
- **Reset.** `prst`=1 forces:
  - FSM to IDLE.
  - `cnt`, `sh`, `data`, `valid` and `ovf` to 0.
  - `s_sck_d` and the synchroniser flops to 0.
  - This applies mid-frame as well. After `prst` falls, reception starts cleanly at the next `ss` falling edge. The master must re-assert `ss`, because a frame already in progress is not resumed.

## Timing
- **Output reset values:** `data`=0, `valid`=0, `ovf`=0, all visible after the first `clk` edge with `prst`=1.
- **Latency.** Reference point: the last `sck` rising edge of a word becomes stable before `clk` edge N.
  - With `SPI_RX_SYNC_EN`: `valid`=1 after edge N+2.
  - Without `SPI_RX_SYNC_EN`: `valid`=1 after edge N.
- **`rx` setup/hold.** `rx` must be stable from at least one `clk` period before each `sck` rise until one period after it. It is sampled in the same pipeline stage as `sck`.
- **`sck` pulse widths.**
  - High and low phases must each be ≥2 `clk` periods with the synchroniser, ≥1 without.
  - Narrower pulses may be missed; this is not an error condition.
- **`ss` timing.** Falling edge must precede the first `sck` rise by ≥2 `clk` periods.
- **`ack` timing.** Must be a single-cycle pulse; a level held high acknowledges each new word on arrival.

## Configuration
- **Macro:** `SPI_RX_SYNC_EN`.
- **Defined:** `sck`, `ss` and `rx` each pass through a 2-flop synchroniser (reset to 0) before use. This is required when the SPI master is asynchronous to `clk`.
- **Not defined:** the inputs are used directly (`s_x = x`). This saves 2 cycles of latency and is only legal when the master is clocked from `clk`.
- Functional behaviour is otherwise identical.

## Test plan
- **Reset values.** Apply `prst` for 2 cycles with `ss`=1 → `data`=0, `valid`=0, `ovf`=0; FSM in IDLE.
- **Single word.** `DATA_LENGTH`=8, `ss` low, shift 0xA5 MSB first (`sck` period 8 `clk`), no `ack` → `data`=0xA5 and `valid`=1 at the latency above; `ack` pulse → `valid`=0 next cycle, `data` stays 0xA5.
- **Overrun.** Shift 0x12 then 0x34 back-to-back under one `ss`, no `ack` → `data`=0x34, `valid`=1, `ovf`=1.
- **Abort.** `ss` rises after 5 bits of 0xFF, then falls and 0x3C is shifted → exactly one completion with `data`=0x3C; no spurious `valid` at the abort.
- **Simultaneous ack.** `ack` pulsed in the same cycle the second word 0x5A completes, after 0x11 was left unacknowledged → `valid` stays 1, `data`=0x5A, `ovf`=0.
- **Reset mid-frame.** `prst` after 4 bits → all outputs 0. Raise and re-lower `ss`, shift 0xC3 → `data`=0xC3, `valid`=1, `ovf`=0.
